// File: rtl/rnn_sampler_pkg.sv
// Shared definitions for the RNN categorical sampler and the softmax block
// that feeds it: FSM state encoding, default sizing constants and a
// constant-foldable ceiling log2 used to size indices and accumulators.
package rnn_sampler_pkg;

    // Default number of output classes (character vocabulary size).
    localparam int DEFAULT_NUM_CLASSES = 65;

    // Default probability width, unsigned Q0.16.
    localparam int DEFAULT_PROB_WIDTH = 16;

    // Default width of one PRNG sample word.
    localparam int DEFAULT_RAND_WIDTH = 32;

    // Sampler control states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DONE  = 3'd4
    } sampler_state_t;

    // Ceiling log2, usable in parameter expressions; never returns less
    // than 1 so that widths derived from it stay legal.
    function automatic int sampler_clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rnn_categorical_sampler.sv
// Inverse-CDF categorical sampler. Pulls one random word from the PRNG,
// then walks the softmax probability stream, accumulating a running sum
// and picking the first class whose cumulative sum exceeds the random
// fraction. The whole stream is always consumed so upstream framing stays
// aligned, and a rounding deficit falls back to the last class.
module rnn_categorical_sampler
    import rnn_sampler_pkg::*;
#(
    parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
    parameter int PROB_WIDTH  = DEFAULT_PROB_WIDTH,
    parameter int RAND_WIDTH  = DEFAULT_RAND_WIDTH,
    parameter int IDX_WIDTH   = sampler_clog2(NUM_CLASSES),
    parameter int ACC_WIDTH   = PROB_WIDTH + sampler_clog2(NUM_CLASSES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  rand_fetch,
    input  logic [RAND_WIDTH-1:0] rand_in,
    input  logic [PROB_WIDTH-1:0] prob_in,
    input  logic                  prob_valid,
    output logic                  prob_ready,
    output logic [IDX_WIDTH-1:0]  sample_index,
    output logic                  sample_valid
);

    localparam logic [IDX_WIDTH-1:0] LAST_INDEX = IDX_WIDTH'(NUM_CLASSES - 1);

    sampler_state_t        state;
    logic [PROB_WIDTH-1:0] rand_frac;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic [IDX_WIDTH-1:0]  count;
    logic [IDX_WIDTH-1:0]  idx;
    logic [IDX_WIDTH-1:0]  idx_next;
    logic                  found;
    logic                  found_next;
    logic                  hit;
    logic                  transfer;
    logic                  last_word;

    // Only the top PROB_WIDTH bits of the random word form the fraction.
    generate
        if (RAND_WIDTH > PROB_WIDTH) begin : g_unused_rand
            logic unused_rand_lsbs;
            assign unused_rand_lsbs = ^rand_in[RAND_WIDTH-PROB_WIDTH-1:0];
        end
    endgenerate

    // Status and handshake outputs decode straight from the state so that
    // an asynchronous reset clears them in the same cycle.
    assign busy         = (state != ST_IDLE);
    assign rand_fetch   = (state == ST_FETCH);
    assign prob_ready   = (state == ST_ACCUM);
    assign sample_valid = (state == ST_DONE);

    assign transfer  = prob_ready && prob_valid;
    assign last_word = (count == LAST_INDEX);

    // Running cumulative sum and first-crossing detection for the word on
    // the input this cycle; the compare is strict so a sum equal to the
    // fraction does not select.
    always_comb begin
        acc_next   = acc + ACC_WIDTH'(prob_in);
        hit        = !found && (acc_next > ACC_WIDTH'(rand_frac));
        found_next = found || hit;
        idx_next   = hit ? count : idx;
    end

    // Draw sequencing: fetch, latch the fraction, accumulate every class,
    // then present the chosen index for one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            rand_frac    <= '0;
            acc          <= '0;
            count        <= '0;
            idx          <= '0;
            found        <= 1'b0;
            sample_index <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    rand_frac <= rand_in[RAND_WIDTH-1 -: PROB_WIDTH];
                    acc       <= '0;
                    count     <= '0;
                    idx       <= '0;
                    found     <= 1'b0;
                    state     <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (transfer) begin
                        acc   <= acc_next;
                        found <= found_next;
                        idx   <= idx_next;
                        count <= count + 1'b1;
                        if (last_word) begin
                            sample_index <= found_next ? idx_next : LAST_INDEX;
                            state        <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rnn_categorical_sampler.sv
// Self-checking bench for rnn_categorical_sampler with four classes.
// Directed vectors check index selection, latency and handshake framing;
// randomized draws with stalls and stray start pulses are checked against
// a cumulative-sum reference; a mid-draw reset checks the abandon path.
module tb_rnn_categorical_sampler;

    localparam int N  = 4;
    localparam int PW = 16;
    localparam int RW = 32;
    localparam int IW = 2;

    typedef logic [N-1:0][PW-1:0] prob_vec_t;

    typedef struct {
        prob_vec_t   probs;
        logic [31:0] rand_word;
        int          exp_idx;
        string       name;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          rand_fetch;
    logic [RW-1:0] rand_in = '0;
    logic [PW-1:0] prob_in = '0;
    logic          prob_valid = 1'b0;
    logic          prob_ready;
    logic [IW-1:0] sample_index;
    logic          sample_valid;

    logic [RW-1:0] next_rand = '0;

    int n_checks = 0;
    int n_errors = 0;

    rnn_categorical_sampler #(
        .NUM_CLASSES(N),
        .PROB_WIDTH (PW),
        .RAND_WIDTH (RW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .rand_fetch  (rand_fetch),
        .rand_in     (rand_in),
        .prob_in     (prob_in),
        .prob_valid  (prob_valid),
        .prob_ready  (prob_ready),
        .sample_index(sample_index),
        .sample_valid(sample_valid)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // PRNG model: presents the prepared word from the cycle after a fetch.
    always @(posedge clock) begin
        if (rand_fetch) begin
            rand_in <= next_rand;
        end
    end

    function automatic prob_vec_t mk4(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                      input logic [PW-1:0] c, input logic [PW-1:0] d);
        prob_vec_t v;
        v[0] = a;
        v[1] = b;
        v[2] = c;
        v[3] = d;
        return v;
    endfunction

    // Reference: first class whose cumulative sum exceeds the fraction,
    // else the last class.
    function automatic int ref_sample(input prob_vec_t p, input logic [31:0] rw);
        int unsigned sum;
        int unsigned frac;
        sum  = 0;
        frac = int'(rw[31:16]);
        for (int i = 0; i < N; i++) begin
            sum = sum + int'(p[i]);
            if (sum > frac) begin
                return i;
            end
        end
        return N - 1;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Run one complete draw, optionally with random stalls and stray
    // start pulses, and report what was observed.
    task automatic apply_stimulus(input prob_vec_t p, input logic [31:0] rw,
                                  input bit gaps, input bit spam,
                                  output int idx, output int latency,
                                  output int fetches, output int ready_cycles,
                                  output int consumed, output int busy_drops,
                                  output int valid_after, output int busy_after,
                                  output int timed_out);
        int  cyc;
        int  k;
        bit  done;
        idx = -1; latency = -1; fetches = 0; ready_cycles = 0;
        busy_drops = 0; cyc = 0; k = 0; done = 1'b0;
        @(negedge clock);
        next_rand  = rw;
        start      = 1'b1;
        prob_valid = 1'b0;
        @(posedge clock);
        while (!done && cyc < 300) begin
            @(negedge clock);
            cyc++;
            if (rand_fetch) fetches++;
            if (!busy) busy_drops++;
            if (prob_ready) ready_cycles++;
            if (sample_valid) begin
                idx     = int'(sample_index);
                latency = cyc;
                done    = 1'b1;
            end
            start = (spam && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                prob_valid = 1'b0;
            end else if (k < N) begin
                prob_valid = 1'b1;
                prob_in    = p[k];
            end else begin
                prob_valid = 1'b1;
                prob_in    = 16'hFFFF;
            end
            if (prob_valid && prob_ready) k++;
        end
        consumed  = k;
        timed_out = done ? 0 : 1;
        @(negedge clock);
        prob_valid  = 1'b0;
        start       = 1'b0;
        valid_after = int'(sample_valid);
        busy_after  = int'(busy);
    endtask

    vec_t vectors[6];

    initial begin
        int idx, lat, fet, rdy, cons, bdrop, vafter, bafter, tout;
        int k;
        prob_vec_t rp;
        logic [31:0] rr;

        vectors[0] = '{mk4(16'h4000, 16'h4000, 16'h4000, 16'h4000), 32'h0000_1234, 0, "quarter_r0"};
        vectors[1] = '{mk4(16'h4000, 16'h4000, 16'h4000, 16'h4000), 32'h7FFF_ABCD, 1, "quarter_r7fff"};
        vectors[2] = '{mk4(16'h4000, 16'h4000, 16'h4000, 16'h4000), 32'h8000_0000, 2, "quarter_r8000"};
        vectors[3] = '{mk4(16'h3FFC, 16'h3FFC, 16'h3FFC, 16'h3FFC), 32'hFFFF_FFFF, 3, "deficit_fallback"};
        vectors[4] = '{mk4(16'h0000, 16'h0000, 16'hFFFF, 16'h0000), 32'h0000_0000, 2, "zero_skip"};
        vectors[5] = '{mk4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 32'h0000_0000, 3, "all_zero"};

        // Reset state while reset is held.
        repeat (3) @(negedge clock);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_fetch", int'(rand_fetch), 0);
        check_output("reset_ready", int'(prob_ready), 0);
        check_output("reset_valid", int'(sample_valid), 0);
        check_output("reset_index", int'(sample_index), 0);
        reset = 1'b0;
        @(negedge clock);

        // Directed vectors, gap-free.
        for (int v = 0; v < 6; v++) begin
            apply_stimulus(vectors[v].probs, vectors[v].rand_word, 1'b0, 1'b0,
                           idx, lat, fet, rdy, cons, bdrop, vafter, bafter, tout);
            check_output({vectors[v].name, "_timeout"}, tout, 0);
            check_output({vectors[v].name, "_index"}, idx, vectors[v].exp_idx);
            check_output({vectors[v].name, "_latency"}, lat, N + 3);
            check_output({vectors[v].name, "_fetches"}, fet, 1);
            check_output({vectors[v].name, "_ready_cycles"}, rdy, N);
            check_output({vectors[v].name, "_consumed"}, cons, N);
            check_output({vectors[v].name, "_busy_drops"}, bdrop, 0);
            check_output({vectors[v].name, "_valid_pulse"}, vafter, 0);
            check_output({vectors[v].name, "_busy_after"}, bafter, 0);
        end

        // Randomized draws with stalls and start pulses while busy.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) begin
                rp[i] = 16'($urandom_range(0, 16'h4400));
            end
            if (t % 5 == 0) rp[$urandom_range(0, N - 1)] = 16'h0000;
            rr = $urandom;
            apply_stimulus(rp, rr, 1'b1, 1'b1,
                           idx, lat, fet, rdy, cons, bdrop, vafter, bafter, tout);
            check_output("rand_timeout", tout, 0);
            check_output("rand_index", idx, ref_sample(rp, rr));
            check_output("rand_fetches", fet, 1);
            check_output("rand_consumed", cons, N);
            check_output("rand_busy_drops", bdrop, 0);
            check_output("rand_valid_pulse", vafter, 0);
        end

        // Known result in sample_index before the reset test.
        apply_stimulus(vectors[2].probs, vectors[2].rand_word, 1'b0, 1'b0,
                       idx, lat, fet, rdy, cons, bdrop, vafter, bafter, tout);
        check_output("pre_reset_index", idx, 2);

        // Reset in the middle of accumulation after two transfers.
        @(negedge clock);
        next_rand = 32'h8000_0000;
        start     = 1'b1;
        @(posedge clock);
        k = 0;
        for (int c = 0; c < 50 && k < 2; c++) begin
            @(negedge clock);
            start      = 1'b0;
            prob_valid = 1'b1;
            prob_in    = 16'h4000;
            if (prob_ready) k++;
            @(posedge clock);
        end
        check_output("mid_reset_transfers", k, 2);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_output("mid_reset_busy", int'(busy), 0);
        check_output("mid_reset_ready", int'(prob_ready), 0);
        check_output("mid_reset_fetch", int'(rand_fetch), 0);
        check_output("mid_reset_valid", int'(sample_valid), 0);
        check_output("mid_reset_index", int'(sample_index), 0);
        @(negedge clock);
        prob_valid = 1'b0;
        reset      = 1'b0;
        @(negedge clock);

        // Fresh draw after the abandoned one.
        apply_stimulus(vectors[1].probs, vectors[1].rand_word, 1'b0, 1'b0,
                       idx, lat, fet, rdy, cons, bdrop, vafter, bafter, tout);
        check_output("post_reset_timeout", tout, 0);
        check_output("post_reset_index", idx, 1);
        check_output("post_reset_latency", lat, N + 3);
        check_output("post_reset_fetches", fet, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rnn_categorical_sampler.md
Name: rnn_categorical_sampler

Overview:
- Consumer end of the PRNG sample interface.
- Draws one 32-bit word from the PRNG via its fetch strobe, then streams the softmax output probabilities of the RNN output layer.
- Selects the class index by inverse-CDF sampling: the first index whose running cumulative sum exceeds the random fraction.
- Sits between the output-layer softmax and the character feedback path that drives the next time step.

Parameters:
NUM_CLASSES, 65, number of output classes (probabilities per draw)
PROB_WIDTH, 16, probability width, unsigned Q0.PROB_WIDTH
RAND_WIDTH, 32, width of PRNG sample word
IDX_WIDTH, clog2(NUM_CLASSES), width of the class index
ACC_WIDTH, PROB_WIDTH+clog2(NUM_CLASSES), cumulative-sum width; cannot overflow

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state and outputs
start  in  1  request one draw; sampled only in IDLE
busy  out  1  high from accepted start until sample_valid pulse inclusive
rand_fetch  out  1  one-cycle strobe to the PRNG fetchSample input
rand_in  in  RAND_WIDTH  PRNG randomArray; valid from the cycle after rand_fetch
prob_in  in  PROB_WIDTH  probability of class prob_idx
prob_valid  in  1  prob_in valid
prob_ready  out  1  sampler accepts prob_in; transfer when valid&&ready
sample_index  out  IDX_WIDTH  chosen class; held until next sample_valid
sample_valid  out  1  one-cycle pulse, sample_index updated

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high. Clock port is clock, reset port is reset.
- Reset values: busy=0, rand_fetch=0, prob_ready=0, sample_index=0, sample_valid=0. Accumulator, counter and latched random value are 0. State is IDLE.
- FSM states: IDLE, FETCH, LATCH, ACCUM, DONE.
- IDLE: start=1 moves to FETCH. busy is high from the next cycle.
- FETCH: rand_fetch=1 for exactly one cycle; go to LATCH.
- LATCH: r <= rand_in[RAND_WIDTH-1 -: PROB_WIDTH] (MSBs). Clear acc, count and the found flag; go to ACCUM.
- ACCUM: prob_ready=1. On each transfer:
  - acc_next = acc + prob_in (zero-extended to ACC_WIDTH).
  - If !found and acc_next > r (strict, r zero-extended): latch idx=count, found=1.
  - count increments.
  - Stalls (prob_valid=0) hold all state, with no timeout.
  - After the transfer with count==NUM_CLASSES-1, go to DONE. All NUM_CLASSES words are always consumed, even after found.
- DONE: sample_valid=1 for one cycle.
  - sample_index = found ? idx : NUM_CLASSES-1. This fallback covers a rounding deficit where the probabilities sum to at most r.
  - busy drops to 0 and the FSM returns to IDLE.
- Latency with no stalls: start accepted at cycle t; rand_fetch at t+1; prob_ready at t+3 .. t+2+NUM_CLASSES; sample_valid at t+3+NUM_CLASSES.
- start outside IDLE is ignored; no queuing.
- start held high in IDLE begins a new draw in the cycle after DONE.
- prob_ready is low outside ACCUM; prob_valid there is ignored.
- Zero-probability classes can never be chosen, except via the fallback when they are last.
- Reset mid-draw: immediate return to IDLE with outputs at reset values. The partial probability stream is abandoned and upstream must restart it. The next start behaves normally.
- No saturation is needed: ACC_WIDTH holds NUM_CLASSES*(2^PROB_WIDTH-1).

Decomposition:
- Shared package rnn_sampler_pkg holds the FSM state enum (sampler_state_t), a clog2 constant function, and the default NUM_CLASSES/PROB_WIDTH constants shared with the softmax block.
- No sub-module; the accumulate/compare datapath and FSM stay in one module.

Test Plan:
- Default N=4, PROB_WIDTH=16 overrides for all scenarios; PRNG modelled by the bench with a defined next value.
- Probabilities {0x4000 x4}, rand MSBs 0x0000 -> sample_index=0, sample_valid exactly 7 cycles after start, rand_fetch one pulse.
- Same probabilities, rand MSBs 0x7FFF -> index 1; rand 0x8000 -> index 2 (strict compare at cumsum 0x8000).
- Probabilities {0x3FFC x4} (sum 0xFFF0), rand 0xFFFF -> fallback index 3.
- Probabilities {0,0,0xFFFF,0}, rand 0x0000 -> index 2; all 4 words consumed and prob_ready deasserts after the 4th.
- Random prob_valid gaps plus start pulses while busy -> same indices as the gap-free run, and exactly one rand_fetch per draw.
- Reset asserted in ACCUM after 2 transfers -> all outputs 0 within the same cycle and prob_ready=0. A fresh draw after release gives the correct index.
